// File: rtl/led_pkg.sv
// Shared constants and FSM state encoding for the LED controller write front end.
package led_pkg;

  localparam logic [7:0] CMD_SET_COL = 8'h2A;
  localparam logic [7:0] CMD_SET_ROW = 8'h2B;
  localparam logic [7:0] CMD_MEM_WR  = 8'h2C;

  localparam int ROW_BITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_COL = 3'd1,
    ST_GET_ROW = 3'd2,
    ST_WR_LO   = 3'd3,
    ST_WR_HI   = 3'd4
  } wr_state_e;

endpackage

// File: rtl/mcu_sync.sv
// Two-flop synchroniser of parameterised width; EDGE_EN adds a third flop
// and a rising-edge output taken from the synchronised value.
module mcu_sync #(
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b1,
  parameter bit   EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{RST_VAL}};
      sync_r <= {WIDTH{RST_VAL}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_r;

      // Delayed copy used only for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_r <= {WIDTH{RST_VAL}};
        end else begin
          prev_r <= sync_r;
        end
      end

      assign rise = sync_r & ~prev_r;
    end else begin : g_no_edge
      assign rise = {WIDTH{1'b0}};
    end
  endgenerate

endmodule

// File: rtl/mcu8080_wr_if.sv
// MCU 8080 write-bus decoder packing 16-bit transfers into 32-bit RAM writes.
// Optional build macro MCU8080_BYTE_SWAP_EN byte-swaps every received data word.
module mcu8080_wr_if
  import led_pkg::*;
#(
  parameter int COL_NUM_LOG2 = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mcu_csx,
  input  logic                             mcu_wrx,
  input  logic                             mcu_rdx,
  input  logic                             mcu_dcx,
  input  logic [15:0]                      mcu_dat,
  input  logic                             enable,
  output logic                             wr,
  output logic [COL_NUM_LOG2+ROW_BITS-1:0] wr_addr,
  output logic [31:0]                      wr_data
);

  logic        csx_sync_s;
  logic        csx_rise_s;
  logic        wrx_rise_s;
  logic        wrx_lvl_unused;
  logic        dcx_sync_s;
  logic        dcx_rise_unused;
  logic [15:0] dat_sync_s;
  logic [15:0] dat_rise_unused;
  logic [15:0] dat_s;
  logic        rdx_unused;
  logic        strobe_s;

  wr_state_e               state_r;
  logic [COL_NUM_LOG2-1:0] col_r;
  logic [ROW_BITS-1:0]     row_r;
  logic [15:0]             lo_r;

  assign rdx_unused = mcu_rdx;

  mcu_sync #(.WIDTH(1), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_csx (
    .clk(clk), .rst_n(rst_n), .d(mcu_csx), .q(csx_sync_s), .rise(csx_rise_s)
  );

  mcu_sync #(.WIDTH(1), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_wrx (
    .clk(clk), .rst_n(rst_n), .d(mcu_wrx), .q(wrx_lvl_unused), .rise(wrx_rise_s)
  );

  mcu_sync #(.WIDTH(1), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_dcx (
    .clk(clk), .rst_n(rst_n), .d(mcu_dcx), .q(dcx_sync_s), .rise(dcx_rise_unused)
  );

  mcu_sync #(.WIDTH(16), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .d(mcu_dat), .q(dat_sync_s), .rise(dat_rise_unused)
  );

`ifdef MCU8080_BYTE_SWAP_EN
  assign dat_s = {dat_sync_s[7:0], dat_sync_s[15:8]};
`else
  assign dat_s = dat_sync_s;
`endif

  // A csx rise seen together with a wrx rise leaves csx_sync_s high, so the strobe is lost.
  assign strobe_s = wrx_rise_s & ~csx_sync_s & enable;

  // Command/data FSM with registered RAM write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      col_r   <= {COL_NUM_LOG2{1'b0}};
      row_r   <= {ROW_BITS{1'b0}};
      lo_r    <= 16'h0000;
      wr      <= 1'b0;
      wr_addr <= {(COL_NUM_LOG2+ROW_BITS){1'b0}};
      wr_data <= 32'h0000_0000;
    end else begin
      wr <= 1'b0;
      if (!enable || csx_rise_s) begin
        state_r <= ST_IDLE;
      end else if (strobe_s && !dcx_sync_s) begin
        case (dat_s[7:0])
          CMD_SET_COL: state_r <= ST_GET_COL;
          CMD_SET_ROW: state_r <= ST_GET_ROW;
          CMD_MEM_WR:  state_r <= ST_WR_LO;
          default:     state_r <= ST_IDLE;
        endcase
      end else if (strobe_s) begin
        case (state_r)
          ST_GET_COL: begin
            col_r   <= dat_s[COL_NUM_LOG2-1:0];
            state_r <= ST_IDLE;
          end
          ST_GET_ROW: begin
            row_r   <= dat_s[ROW_BITS-1:0];
            state_r <= ST_IDLE;
          end
          ST_WR_LO: begin
            lo_r    <= dat_s;
            state_r <= ST_WR_HI;
          end
          ST_WR_HI: begin
            wr      <= 1'b1;
            wr_addr <= {row_r, col_r};
            wr_data <= {dat_s, lo_r};
            state_r <= ST_WR_LO;
            if (col_r == {COL_NUM_LOG2{1'b1}}) begin
              col_r <= {COL_NUM_LOG2{1'b0}};
              row_r <= row_r + {{(ROW_BITS-1){1'b0}}, 1'b1};
            end else begin
              col_r <= col_r + {{(COL_NUM_LOG2-1){1'b0}}, 1'b1};
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_mcu8080_wr_if.sv
// Directed bench for mcu8080_wr_if: bus-level stimulus with hand-computed results.
module tb_mcu8080_wr_if;

  logic        clk;
  logic        rst_n;
  logic        mcu_csx;
  logic        mcu_wrx;
  logic        mcu_rdx;
  logic        mcu_dcx;
  logic [15:0] mcu_dat;
  logic        enable;
  logic        wr;
  logic [12:0] wr_addr;
  logic [31:0] wr_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  logic        prev_wr  = 1'b0;
  logic [3:0]  lat_samp;
  int          base;

  mcu8080_wr_if #(.COL_NUM_LOG2(8)) dut (
    .clk(clk), .rst_n(rst_n), .mcu_csx(mcu_csx), .mcu_wrx(mcu_wrx),
    .mcu_rdx(mcu_rdx), .mcu_dcx(mcu_dcx), .mcu_dat(mcu_dat),
    .enable(enable), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counter plus back-to-back guard, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr) begin
      wr_count++;
      check("no_back_to_back_wr", {31'd0, prev_wr}, 32'd0);
    end
    prev_wr = wr;
  end

  function automatic logic [15:0] sw(input logic [15:0] x);
`ifdef MCU8080_BYTE_SWAP_EN
    return {x[7:0], x[15:8]};
`else
    return x;
`endif
  endfunction

  // Raw bus cycle; records wr at the negedges after edges k..k+3.
  task automatic bus_write(input logic dcx, input logic [15:0] dat);
    @(negedge clk);
    mcu_dcx = dcx;
    mcu_dat = dat;
    mcu_wrx = 1'b0;
    repeat (4) @(negedge clk);
    mcu_wrx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lat_samp[i] = wr;
    end
  endtask

  task automatic cmd(input logic [7:0] c);
    bus_write(1'b0, sw({8'h00, c}));
  endtask

  task automatic dat(input logic [15:0] d);
    bus_write(1'b1, sw(d));
  endtask

  initial begin
    rst_n   = 1'b0;
    mcu_csx = 1'b1;
    mcu_wrx = 1'b1;
    mcu_rdx = 1'b1;
    mcu_dcx = 1'b1;
    mcu_dat = 16'h0000;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_wr", {31'd0, wr}, 32'd0);
    check("reset_addr", {19'd0, wr_addr}, 32'd0);
    check("reset_data", wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    mcu_csx = 1'b0;
    repeat (4) @(negedge clk);

    // Data strobe in IDLE is discarded
    dat(16'h1234);
    check("idle_data_no_wr", wr_count, 0);

    // Basic write with latency
    cmd(8'h2A); dat(16'h0005);
    cmd(8'h2B); dat(16'h0003);
    cmd(8'h2C); dat(16'hAAAA);
    check("basic_no_wr_after_lo", wr_count, 0);
    dat(16'h5555);
    check("basic_latency", {28'd0, lat_samp}, 32'h4);
    check("basic_count", wr_count, 1);
    check("basic_addr", {19'd0, wr_addr}, 32'h0305);
    check("basic_data", wr_data, 32'h5555AAAA);

    // Unknown command then data: nothing written, outputs hold
    cmd(8'h55); dat(16'h9999); dat(16'h8888);
    check("unknown_cmd_count", wr_count, 1);
    check("outputs_hold", wr_data, 32'h5555AAAA);

    // Column and row wrap
    cmd(8'h2A); dat(16'h00FF);
    cmd(8'h2B); dat(16'h001F);
    cmd(8'h2C); dat(16'h0102); dat(16'h0304);
    check("wrap_last_addr", {19'd0, wr_addr}, 32'h1FFF);
    check("wrap_last_data", wr_data, 32'h03040102);
    dat(16'h0506); dat(16'h0708);
    check("wrap_first_addr", {19'd0, wr_addr}, 32'h0000);
    check("wrap_first_data", wr_data, 32'h07080506);
    check("wrap_count", wr_count, 3);

    // csx release drops pending low half, address preserved (row0 col1)
    cmd(8'h2C); dat(16'h1111);
    @(negedge clk); mcu_csx = 1'b1;
    repeat (6) @(negedge clk); mcu_csx = 1'b0;
    repeat (4) @(negedge clk);
    dat(16'hDEAD);
    check("csx_idle_discard", wr_count, 3);
    cmd(8'h2C); dat(16'h2222); dat(16'h3333);
    check("pending_drop_data", wr_data, 32'h33332222);
    check("pending_drop_addr", {19'd0, wr_addr}, 32'h0001);
    check("pending_drop_count", wr_count, 4);

    // Enable gating
    enable = 1'b0;
    cmd(8'h2C); dat(16'h4444); dat(16'h5555);
    check("enable_gated_count", wr_count, 4);
    enable = 1'b1;
    cmd(8'h2C); dat(16'h6666); dat(16'h7777);
    check("enable_resume_addr", {19'd0, wr_addr}, 32'h0002);
    check("enable_resume_data", wr_data, 32'h77776666);

    // Reset mid-burst clears outputs and forgets the burst
    cmd(8'h2C); dat(16'hAAAA);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_wr", {31'd0, wr}, 32'd0);
    check("midrst_addr", {19'd0, wr_addr}, 32'd0);
    check("midrst_data", wr_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = wr_count;
    dat(16'hBBBB); dat(16'hCCCC);
    check("midrst_no_wr", wr_count, base);
    cmd(8'h2C); dat(16'h0001); dat(16'h0002);
    check("midrst_restart_addr", {19'd0, wr_addr}, 32'h0000);
    check("midrst_restart_data", wr_data, 32'h00020001);

`ifdef MCU8080_BYTE_SWAP_EN
    bus_write(1'b0, 16'h2A00); bus_write(1'b1, 16'h0700);
    bus_write(1'b0, 16'h2B00); bus_write(1'b1, 16'h0000);
    bus_write(1'b0, 16'h2C00); bus_write(1'b1, 16'h3412); bus_write(1'b1, 16'h7856);
    check("swap_addr", {19'd0, wr_addr}, 32'h0007);
    check("swap_data", wr_data, 32'h56781234);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcu8080_wr_if.md
# mcu8080_wr_if

Write-side front end of the LED controller. It receives MCU 8080-style parallel bus writes on the 100 MHz `clk_100` domain and decodes command and data phases. It packs 16-bit data transfers into 32-bit pixel words and issues single-cycle write strobes with auto-incrementing addresses into the HUB75 frame dual-port RAM, which the matrix scan engine reads.

## Interface
Parameters:
- `COL_NUM_LOG2`, default 8: log2 of columns per row. The address is {row[4:0], col[COL_NUM_LOG2-1:0]}.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  100 MHz write-domain clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `mcu_csx`  in  1  chip select, active low, asynchronous.
- `mcu_wrx`  in  1  write strobe, active low; data is captured on its rising edge.
- `mcu_rdx`  in  1  read strobe; ignored.
- `mcu_dcx`  in  1  0 = command phase, 1 = data phase.
- `mcu_dat`  in  16  parallel data bus.
- `enable`  in  1  when 0, strobes are ignored and the FSM is held in IDLE.
- `wr`  out  1  one-cycle RAM write strobe.
- `wr_addr`  out  COL_NUM_LOG2+5  RAM word address.
- `wr_data`  out  32  packed pixel word.

## Operation
- **Input synchronisation.** `mcu_csx`, `mcu_wrx`, `mcu_dcx` and `mcu_dat` each pass through two flops.
- **Strobe detection.**
  - A strobe is a rising edge of the synchronised `wrx`, detected against a third flop.
  - A strobe is valid only if the synchronised `csx` is 0 and `enable` is 1.
- **Command decode.** Commands use `dat[7:0]` when `dcx`=0:
  - 0x2A goes to GET_COL.
  - 0x2B goes to GET_ROW.
  - 0x2C goes to WR_LO and clears the half-word flag.
  - Any other command goes to IDLE and has no other effect.
- **FSM states:** IDLE, GET_COL, GET_ROW, WR_LO, WR_HI.
  - GET_COL: a data strobe loads col = dat[COL_NUM_LOG2-1:0], then goes to IDLE.
  - GET_ROW: a data strobe loads row = dat[4:0], then goes to IDLE.
  - WR_LO: a data strobe latches lo = dat, then goes to WR_HI.
  - WR_HI: a data strobe drives wr_data = {dat, lo}, wr_addr = {row, col} and wr = 1 for one cycle, advances the address, then returns to WR_LO.
  - A data strobe in IDLE is discarded.
  - A command strobe is accepted in any state. A pending low half in WR_HI is dropped.
- **Address advance.**
  - col increments by 1 per word.
  - When col reaches 2^COL_NUM_LOG2-1 it wraps to 0 and row increments.
  - Row 31 wraps to row 0. There is no error on wrap.
- **Chip-select release.** A rising edge of the synchronised `csx` forces the FSM to IDLE and drops any pending low half. col and row are retained.
- **Enable.** While `enable`=0, the FSM goes to IDLE and `wr` is held at 0. col and row are retained.

## Timing
- **Reset values:**
  - `wr`=0, `wr_addr`=0, `wr_data`=0.
  - FSM=IDLE, col=0, row=0, lo=0.
  - All synchroniser flops reset high, except the data flops, which reset to 0.
- **Latency.** Call the first `clk` edge that samples `mcu_wrx`=1 edge k. `wr` is 1 in the cycle following edge k+2. `wr_addr` and `wr_data` are valid in that same cycle and hold until the next write.
- **Bus timing:**
  - `mcu_wrx` low time ≥ 3 clk and high time ≥ 3 clk.
  - `mcu_dat` and `mcu_dcx` are stable from 3 clk before to 1 clk after the `wrx` rising edge.
  - `csx` is low at least 3 clk before the first `wrx` falling edge.
- **Throughput.** At most one strobe per 6 clk, so `wr` never asserts on consecutive cycles.
- **Simultaneous events.** If a `csx` rise and a `wrx` rise are seen in the same cycle, the strobe is discarded and `csx` handling wins.
- **Reset mid-operation.** Outputs return to reset values immediately. A burst must restart with 0x2A, 0x2B, 0x2C.

## Configuration
- Macro: `MCU8080_BYTE_SWAP_EN`.
- Defined: every 16-bit `mcu_dat` is byte-swapped ({dat[7:0], dat[15:8]}) before any use, including command decode, col/row loads and pixel packing.
- Not defined: data is used as received.

## Structure
- Package `led_pkg` holds:
  - The command constants CMD_SET_COL=8'h2A, CMD_SET_ROW=8'h2B and CMD_MEM_WR=8'h2C.
  - The FSM state enum.
  - ROW_BITS=5.
- Sub-module `mcu_sync` is a parameterised-width two-flop synchroniser with an optional rising-edge output. It is instantiated for the control lines and the data bus.

## Test plan
- **Reset defaults.** Reset, then `wr`=0 and `wr_addr`=0. Drive one data strobe 0x1234 in IDLE → no `wr`.
- **Basic write.** Send 0x2A, data 0x0005, 0x2B, data 0x0003, 0x2C, then data 0xAAAA and 0x5555 → one `wr`, wr_addr=(3<<8)|5, wr_data=0x5555AAAA, asserted 3 edges after the sampling of the second `wrx` rise.
- **Column wrap.** Set col=255, row=31, send 0x2C and two words → wr_addr=0x1FFF. Two more words → wr_addr=0x0000.
- **Pending half dropped.** After 0x2C, send one data word 0x1111, raise `csx`, lower `csx`, send 0x2C, 0x2222 and 0x3333 → wr_data=0x33332222 at the preserved address.
- **Enable gating.** With `enable`=0, send a full 0x2C plus two-word burst → no `wr`.
- **Byte swap.** With `MCU8080_BYTE_SWAP_EN` defined, send command 0x2A00 then data 0x0700 → col=7.
